// File: rtl/adc_capture.sv
`default_nettype none
// ============================================================================
// adc_capture : ADC sample-clock generator, pre/post-trigger circular capture
//               buffer and valid/ready record readout, oldest sample first.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_capture #(
   parameter int DATA_W   = 14,
   parameter int ADDR_W   = 10,
   parameter int CLK_DIV  = 2,
   parameter int PRE_TRIG = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] AD_DATA,
   input  logic              AD_OTR,
   output logic              AD_CLK,
   input  logic              arm,
   input  logic              force_trig,
   input  logic [DATA_W-1:0] trig_level,
   input  logic              trig_rising,
   output logic              busy,
   output logic              done,
   output logic              otr_flag,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              rd_last
);
   localparam int DEPTH = 2**ADDR_W;
   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int CNT_W = ADDR_W + 1;

   localparam logic [DIV_W-1:0]  C_DIV_MAX  = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0]  C_DIV_HALF = DIV_W'(CLK_DIV / 2);
   localparam logic [ADDR_W-1:0] C_PRE      = ADDR_W'(PRE_TRIG);
   localparam logic [CNT_W-1:0]  C_PRE_M1   = CNT_W'(PRE_TRIG - 1);
   localparam logic [CNT_W-1:0]  C_POST_M1  = CNT_W'(DEPTH - PRE_TRIG - 1);
   localparam logic [CNT_W-1:0]  C_DEPTH    = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]  C_DEPTH_M1 = CNT_W'(DEPTH - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_PREFILL   = 3'd1;
   localparam logic [2:0] S_WAIT_TRIG = 3'd2;
   localparam logic [2:0] S_POST      = 3'd3;
   localparam logic [2:0] S_READOUT   = 3'd4;

   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   logic              ad_clk_q, ad_clk_d;
   logic              samp_q, samp_d;
   logic [DATA_W-1:0] cur_q, cur_d, prev_q, prev_d;
   logic              otr_s_q, otr_s_d, force_s_q, force_s_d;
   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, rd_issued_q, rd_issued_d;
   logic              otr_flag_q, otr_flag_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
   logic              done_q, done_d;

   logic              samp_en, capturing, level_hit, trig_hit, rd_fire, mem_we;
   logic [DATA_W-1:0] mem [DEPTH];

   assign samp_en   = (div_cnt_q == C_DIV_MAX);
   assign capturing = (state_q == S_PREFILL) || (state_q == S_WAIT_TRIG) || (state_q == S_POST);
   assign level_hit = trig_rising ? ((prev_q <  trig_level) && (cur_q >= trig_level))
                                  : ((prev_q >= trig_level) && (cur_q <  trig_level));
   assign trig_hit  = level_hit || force_s_q;
   assign rd_fire   = rd_valid_q && rd_ready;

   always_comb begin
      div_cnt_d   = (div_cnt_q == C_DIV_MAX) ? '0 : div_cnt_q + 1'b1;
      ad_clk_d    = (div_cnt_d < C_DIV_HALF);
      // samp_q marks the cycle in which cur_q holds a freshly registered sample
      samp_d      = samp_en;
      cur_d       = samp_en ? AD_DATA    : cur_q;
      prev_d      = samp_en ? cur_q      : prev_q;
      otr_s_d     = samp_en ? AD_OTR     : otr_s_q;
      force_s_d   = samp_en ? force_trig : force_s_q;

      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      cnt_d       = cnt_q;
      rd_issued_d = rd_issued_q;
      otr_flag_d  = otr_flag_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = rd_valid_q;
      rd_last_d   = rd_last_q;
      done_d      = 1'b0;
      mem_we      = 1'b0;

      if (capturing && samp_q) begin
         mem_we   = 1'b1;
         wr_ptr_d = wr_ptr_q + 1'b1;
         if (otr_s_q) otr_flag_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (arm) begin
               state_d    = S_PREFILL;
               wr_ptr_d   = '0;
               cnt_d      = '0;
               otr_flag_d = 1'b0;
            end
         end
         S_PREFILL: begin
            if (samp_q) begin
               if (cnt_q == C_PRE_M1) begin
                  cnt_d   = '0;
                  state_d = S_WAIT_TRIG;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_WAIT_TRIG: begin
            // PRE_TRIG >= 1 guarantees prev_q is already a post-arm sample here
            if (samp_q && trig_hit) begin
               rd_ptr_d    = wr_ptr_q - C_PRE;
               rd_issued_d = '0;
               cnt_d       = CNT_W'(1);
               state_d     = (C_POST_M1 == '0) ? S_READOUT : S_POST;
            end
         end
         S_POST: begin
            if (samp_q) begin
               if (cnt_q == C_POST_M1) state_d = S_READOUT;
               else                    cnt_d   = cnt_q + 1'b1;
            end
         end
         S_READOUT: begin
            // Output register doubles as the RAM read register; it only loads when free
            if ((rd_issued_q != C_DEPTH) && (!rd_valid_q || rd_ready)) begin
               rd_data_d   = mem[rd_ptr_q];
               rd_valid_d  = 1'b1;
               rd_last_d   = (rd_issued_q == C_DEPTH_M1);
               rd_ptr_d    = rd_ptr_q + 1'b1;
               rd_issued_d = rd_issued_q + 1'b1;
            end else if (rd_fire) begin
               rd_valid_d = 1'b0;
               rd_last_d  = 1'b0;
            end
            if (rd_fire && rd_last_q) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q   <= '0;
         ad_clk_q    <= 1'b0;
         samp_q      <= 1'b0;
         cur_q       <= '0;
         prev_q      <= '0;
         otr_s_q     <= 1'b0;
         force_s_q   <= 1'b0;
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         rd_issued_q <= '0;
         otr_flag_q  <= 1'b0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         rd_last_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         div_cnt_q   <= div_cnt_d;
         ad_clk_q    <= ad_clk_d;
         samp_q      <= samp_d;
         cur_q       <= cur_d;
         prev_q      <= prev_d;
         otr_s_q     <= otr_s_d;
         force_s_q   <= force_s_d;
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         rd_issued_q <= rd_issued_d;
         otr_flag_q  <= otr_flag_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         rd_last_q   <= rd_last_d;
         done_q      <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_ptr_q] <= cur_q;
   end

   assign AD_CLK   = ad_clk_q;
   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;
   assign otr_flag = otr_flag_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign rd_last  = rd_last_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture.sv
`default_nettype none
// ============================================================================
// tb_adc_capture : randomized self-checking bench for adc_capture against a
//                  record-level model of the trigger/capture rules.
// Revision       : 1.0 - initial release
// ============================================================================
module tb_adc_capture;
   localparam int DATA_W   = 14;
   localparam int ADDR_W   = 4;
   localparam int CLK_DIV  = 2;
   localparam int PRE_TRIG = 4;
   localparam int DEPTH    = 1 << ADDR_W;
   localparam int M_UP = 0, M_DOWN = 1, M_CONST = 2, M_RAND = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [DATA_W-1:0] AD_DATA = '0;
   logic              AD_OTR = 1'b0;
   logic              AD_CLK;
   logic              arm = 1'b0;
   logic              force_trig = 1'b0;
   logic [DATA_W-1:0] trig_level = '0;
   logic              trig_rising = 1'b1;
   logic              busy, done, otr_flag;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid, rd_last;
   logic              rd_ready = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DATA_W-1:0] vals[$];
   bit                frcs[$];
   bit                otrs[$];
   logic [DATA_W-1:0] got[$];
   bit                lasts[$];
   logic [DATA_W-1:0] exp_q[$];
   bit                exp_otr;
   int                done_cnt, stall_err, extra, timeout;
   bit                otr_hi, otr_lo, end_busy, mid_busy, mid_valid, early_otr;

   always #5 clk = ~clk;

   adc_capture #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CLK_DIV(CLK_DIV), .PRE_TRIG(PRE_TRIG)
   ) dut (
      .clk(clk), .rst_n(rst_n), .AD_DATA(AD_DATA), .AD_OTR(AD_OTR), .AD_CLK(AD_CLK),
      .arm(arm), .force_trig(force_trig), .trig_level(trig_level),
      .trig_rising(trig_rising), .busy(busy), .done(done), .otr_flag(otr_flag),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last)
   );

   function automatic logic [DATA_W-1:0] gen(input int mode, input int k);
      case (mode)
         M_UP:    return DATA_W'(50 + k);
         M_DOWN:  return DATA_W'(200 - k);
         M_CONST: return 14'h1234;
         default: return DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
      endcase
   endfunction

   // Reference: first qualifying sample after the prefill window is the trigger;
   // the record is the PRE_TRIG samples before it plus DEPTH-PRE_TRIG from it on.
   function automatic void build_expected();
      int  t;
      bit  lvl;
      t = -1;
      exp_q.delete();
      exp_otr = 1'b0;
      for (int i = PRE_TRIG; i < vals.size() && t < 0; i++) begin
         if (trig_rising) lvl = (vals[i-1] <  trig_level) && (vals[i] >= trig_level);
         else             lvl = (vals[i-1] >= trig_level) && (vals[i] <  trig_level);
         if (lvl || frcs[i]) t = i;
      end
      if (t >= 0) begin
         for (int j = t - PRE_TRIG; j < t + DEPTH - PRE_TRIG && j < vals.size(); j++)
            exp_q.push_back(vals[j]);
         for (int j = 0; j < t + DEPTH - PRE_TRIG && j < otrs.size(); j++)
            exp_otr |= otrs[j];
      end
   endfunction

   // Presents one sample per AD_CLK period, arms on the first, then drains the
   // record with rd_ready asserted rdy_pct percent of the time.
   task automatic capture(input int mode, input int force_k, input int otr_v,
                          input int rst_v, input int rdy_pct);
      int                k, tail, w;
      bit                pv, pr, pl, sampling;
      logic [DATA_W-1:0] pd;
      vals.delete(); frcs.delete(); otrs.delete(); got.delete(); lasts.delete();
      done_cnt = 0; stall_err = 0; extra = 0; timeout = 1;
      otr_hi = 0; otr_lo = 0; end_busy = 1; mid_busy = 0; mid_valid = 0; early_otr = 1;
      pv = 0; pr = 0; pl = 0; pd = '0; tail = 0; sampling = 1; w = 0;
      @(negedge clk);
      while (AD_CLK !== 1'b1 && w < 8) begin
         @(negedge clk);
         w++;
      end
      AD_DATA    = gen(mode, 0);
      AD_OTR     = (otr_v == int'(AD_DATA));
      force_trig = (force_k == 0);
      @(negedge clk);
      arm = 1'b1;
      vals.push_back(AD_DATA); frcs.push_back(force_trig); otrs.push_back(AD_OTR);
      k = 1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         arm = 1'b0;
         if (sampling) begin
            if (AD_CLK === 1'b1) begin
               AD_DATA    = gen(mode, k);
               AD_OTR     = (otr_v == int'(AD_DATA));
               force_trig = (force_k == k);
            end else begin
               vals.push_back(AD_DATA); frcs.push_back(force_trig); otrs.push_back(AD_OTR);
               if (k == 2) early_otr = otr_flag;
               if (k == 30) begin
                  mid_busy  = busy;
                  mid_valid = rd_valid;
               end
               if (int'(AD_DATA) == rst_v) begin
                  #1 rst_n = 1'b0;
                  AD_OTR = 1'b0; force_trig = 1'b0;
                  return;
               end
               k++;
            end
         end
         if (rd_valid === 1'b1) begin
            sampling   = 0;
            AD_OTR     = 1'b0;
            force_trig = 1'b0;
         end
         if (pv && !pr) begin
            if (rd_valid !== 1'b1 || rd_data !== pd || rd_last !== pl) stall_err++;
         end
         if (done === 1'b1) done_cnt++;
         if (got.size() == DEPTH) begin
            if (rd_valid === 1'b1) extra++;
            tail++;
            if (tail == 4) begin
               end_busy = busy;
               timeout  = 0;
               rd_ready = 1'b0;
               break;
            end
         end
         rd_ready = (int'($urandom_range(0, 99)) < rdy_pct);
         if (rd_valid === 1'b1 && rd_ready && got.size() < DEPTH) begin
            got.push_back(rd_data);
            lasts.push_back(rd_last);
            if (otr_flag === 1'b1) otr_hi = 1; else otr_lo = 1;
         end
         pv = (rd_valid === 1'b1); pr = rd_ready; pd = rd_data; pl = (rd_last === 1'b1);
      end
   endtask

   task automatic test_reset();
      logic pclk;
      bit   anyb;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({AD_CLK, busy, done, otr_flag, rd_valid, rd_last, rd_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got clk/busy/done/otr/vld/last=%b%b%b%b%b%b data=%h want all 0",
                  AD_CLK, busy, done, otr_flag, rd_valid, rd_last, rd_data);
      end
      rst_n = 1'b1;
      @(negedge clk);
      pclk = AD_CLK;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_checks++;
         if (AD_CLK === pclk || $isunknown(AD_CLK)) begin
            n_fail++;
            $display("FAIL ad_clk_toggle[%0d]: got %b want %b", i, AD_CLK, ~pclk);
         end
         pclk = AD_CLK;
      end
      anyb = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy !== 1'b0) anyb = 1;
      end
      n_checks++;
      if (anyb) begin
         n_fail++;
         $display("FAIL idle_busy: got busy=1 without arm want 0");
      end
   endtask

   task automatic test_rising();
      trig_level = 14'd100; trig_rising = 1'b1;
      capture(M_UP, -1, -1, -1, 100);
      build_expected();
      n_checks++;
      if (timeout != 0) begin n_fail++; $display("FAIL rise_timeout: got %0d want 0", timeout); end
      for (int j = 0; j < DEPTH; j++) begin
         n_checks++;
         if (j >= got.size() || j >= exp_q.size() || got[j] !== exp_q[j]) begin
            n_fail++;
            $display("FAIL rise_word[%0d]: got %0d want %0d", j,
                     (j < got.size()) ? got[j] : '0, (j < exp_q.size()) ? exp_q[j] : '0);
         end
      end
      n_checks++;
      if (got.size() != DEPTH || got[0] !== 14'd96 || got[DEPTH-1] !== 14'd111) begin
         n_fail++;
         $display("FAIL rise_endpoints: got size %0d want 16 words 96..111", got.size());
      end
      for (int j = 0; j < lasts.size(); j++) begin
         n_checks++;
         if (lasts[j] !== (j == DEPTH - 1)) begin
            n_fail++;
            $display("FAIL rise_last[%0d]: got %b want %b", j, lasts[j], j == DEPTH - 1);
         end
      end
      n_checks++;
      if (done_cnt != 1) begin n_fail++; $display("FAIL rise_done: got %0d pulses want 1", done_cnt); end
      n_checks++;
      if (end_busy !== 1'b0) begin n_fail++; $display("FAIL rise_busy_end: got %b want 0", end_busy); end
      n_checks++;
      if (otr_hi !== 1'b0) begin n_fail++; $display("FAIL rise_otr: got 1 want 0"); end
   endtask

   task automatic test_falling();
      trig_level = 14'd150; trig_rising = 1'b0;
      capture(M_DOWN, -1, -1, -1, 100);
      build_expected();
      n_checks++;
      if (timeout != 0) begin n_fail++; $display("FAIL fall_timeout: got %0d want 0", timeout); end
      for (int j = 0; j < DEPTH; j++) begin
         n_checks++;
         if (j >= got.size() || j >= exp_q.size() || got[j] !== exp_q[j]) begin
            n_fail++;
            $display("FAIL fall_word[%0d]: got %0d want %0d", j,
                     (j < got.size()) ? got[j] : '0, (j < exp_q.size()) ? exp_q[j] : '0);
         end
      end
      n_checks++;
      if (got.size() > PRE_TRIG && got[PRE_TRIG] !== 14'd149) begin
         n_fail++;
         $display("FAIL fall_trig_index: got %0d want 149", got[PRE_TRIG]);
      end
      n_checks++;
      if (done_cnt != 1) begin n_fail++; $display("FAIL fall_done: got %0d want 1", done_cnt); end
   endtask

   task automatic test_forced();
      trig_level = 14'h3fff; trig_rising = 1'b1;
      capture(M_CONST, 10, -1, -1, 100);
      n_checks++;
      if (timeout != 0) begin n_fail++; $display("FAIL force_timeout: got %0d want 0", timeout); end
      for (int j = 0; j < DEPTH; j++) begin
         n_checks++;
         if (j >= got.size() || got[j] !== 14'h1234) begin
            n_fail++;
            $display("FAIL force_word[%0d]: got %h want 1234", j, (j < got.size()) ? got[j] : '0);
         end
      end
      n_checks++;
      if (done_cnt != 1) begin n_fail++; $display("FAIL force_done: got %0d want 1", done_cnt); end
   endtask

   task automatic test_prefill_ignored();
      trig_level = 14'd52; trig_rising = 1'b1;
      capture(M_UP, 40, -1, -1, 100);
      build_expected();
      n_checks++;
      if (mid_busy !== 1'b1 || mid_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL prefill_wait: got busy=%b valid=%b want busy=1 valid=0", mid_busy, mid_valid);
      end
      for (int j = 0; j < DEPTH; j++) begin
         n_checks++;
         if (j >= got.size() || j >= exp_q.size() || got[j] !== exp_q[j]) begin
            n_fail++;
            $display("FAIL prefill_word[%0d]: got %0d want %0d", j,
                     (j < got.size()) ? got[j] : '0, (j < exp_q.size()) ? exp_q[j] : '0);
         end
      end
   endtask

   task automatic test_backpressure();
      for (int r = 0; r < 3; r++) begin
         trig_level = 14'd8192; trig_rising = 1'(r & 1);
         capture(M_RAND, -1, -1, -1, 50);
         build_expected();
         n_checks++;
         if (timeout != 0) begin n_fail++; $display("FAIL bp_timeout[%0d]: got %0d want 0", r, timeout); end
         for (int j = 0; j < DEPTH; j++) begin
            n_checks++;
            if (j >= got.size() || j >= exp_q.size() || got[j] !== exp_q[j]) begin
               n_fail++;
               $display("FAIL bp_word[%0d][%0d]: got %h want %h", r, j,
                        (j < got.size()) ? got[j] : '0, (j < exp_q.size()) ? exp_q[j] : '0);
            end
         end
         n_checks++;
         if (stall_err != 0 || extra != 0) begin
            n_fail++;
            $display("FAIL bp_stable[%0d]: got %0d unstable, %0d extra want 0, 0", r, stall_err, extra);
         end
         n_checks++;
         if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done[%0d]: got %0d want 1", r, done_cnt); end
      end
   endtask

   task automatic test_overrange();
      trig_level = 14'd100; trig_rising = 1'b1;
      capture(M_UP, -1, 103, -1, 100);
      build_expected();
      n_checks++;
      if ({otr_hi, otr_lo} !== {exp_otr, ~exp_otr}) begin
         n_fail++;
         $display("FAIL otr_sticky: got seen1=%b seen0=%b want %b %b", otr_hi, otr_lo, exp_otr, ~exp_otr);
      end
      capture(M_UP, -1, -1, -1, 100);
      n_checks++;
      if (early_otr !== 1'b0 || otr_hi !== 1'b0) begin
         n_fail++;
         $display("FAIL otr_clear: got early=%b readout=%b want 0 0", early_otr, otr_hi);
      end
   endtask

   task automatic test_reset_mid();
      trig_level = 14'd100; trig_rising = 1'b1;
      capture(M_UP, -1, -1, 103, 100);
      #1;
      n_checks++;
      if ({busy, rd_valid, done, otr_flag, AD_CLK} !== 5'b0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got busy/vld/done/otr/clk=%b%b%b%b%b want 00000",
                  busy, rd_valid, done, otr_flag, AD_CLK);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      capture(M_UP, -1, -1, -1, 100);
      build_expected();
      n_checks++;
      if (timeout != 0 || done_cnt != 1) begin
         n_fail++;
         $display("FAIL midreset_rearm: got timeout=%0d done=%0d want 0 1", timeout, done_cnt);
      end
      for (int j = 0; j < DEPTH; j++) begin
         n_checks++;
         if (j >= got.size() || j >= exp_q.size() || got[j] !== exp_q[j]) begin
            n_fail++;
            $display("FAIL midreset_word[%0d]: got %0d want %0d", j,
                     (j < got.size()) ? got[j] : '0, (j < exp_q.size()) ? exp_q[j] : '0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_rising();
      test_falling();
      test_forced();
      test_prefill_ignored();
      test_backpressure();
      test_overrange();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
